// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_pkg: shared FSM encodings, status bit positions and frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;
  localparam int READY = 8;
  localparam int OVF = 9;
  localparam int PERR = 10;
  localparam int FERR = 11;
  localparam int CNT_LSB = 12;
  localparam int FRAME_LEN = 11;
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: keyboard lines plus MIO-side strobes and status word
interface ps2_kbd_rx_if;
  logic ps2_clk;
  logic ps2_data;
  logic rd_en;
  logic clr_err;
  logic [31:0] status;
  logic irq;
  modport slave(input ps2_clk, ps2_data, rd_en, clr_err, output status, irq);
  modport master(output ps2_clk, ps2_data, rd_en, clr_err, input status, irq);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: show-ahead byte FIFO; drops pushes when full unless a pop frees space
module ps2_rx_fifo import ps2_pkg::*; #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [FIFO_AW:0] count,
  output logic             full,
  output logic             empty
);
  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (FIFO_AW+1)'(2**FIFO_AW);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      for (int i = 0; i < 2**FIFO_AW; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wp_q] <= din;
      wp_q <= wp_q + FIFO_AW'(do_push);
      rp_q <= rp_q + FIFO_AW'(do_pop);
      cnt_q <= cnt_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with FIFO, sticky errors and MIO status word
module ps2_kbd_rx import ps2_pkg::*; #(
  parameter int FIFO_AW = 3,
  parameter int FILTER = 4,
  parameter int TIMEOUT = 100000
) (
  input logic clk,
  input logic RSTN,
  ps2_kbd_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0]       csync_q, dsync_q;
  logic             fclk_q, fclk_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  state_e           state_q, state_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [9:0]       shr_q, shr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic             flip, bit_ev, din, timeout, push, par_ok, stop_ok, full, empty;
  logic [7:0]       head;
  logic [FIFO_AW:0] count;
  logic [31:0]      status;
  assign din = dsync_q[1];
  assign flip = (csync_q[1] != fclk_q) && fcnt_q == FW'(FILTER - 1);
  assign bit_ev = flip && fclk_q;
  assign timeout = state_q == RECV && tmo_q == TW'(TIMEOUT);
  assign par_ok = ^shr_q[8:0];
  assign stop_ok = shr_q[9];
  assign push = state_q == CHECK && par_ok && stop_ok;
  // two-flop synchronisers; lines idle high so they reset to 1
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      csync_q <= '1;
      dsync_q <= '1;
    end else begin
      csync_q <= {csync_q[0], bus.ps2_clk};
      dsync_q <= {dsync_q[0], bus.ps2_data};
    end
  // glitch filter: level flips after FILTER consecutive disagreeing samples
  always_comb begin
    fclk_d = flip ? ~fclk_q : fclk_q;
    fcnt_d = (csync_q[1] == fclk_q || flip) ? '0 : fcnt_q + FW'(1);
  end
  // filter state
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      fclk_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      fclk_q <= fclk_d;
      fcnt_q <= fcnt_d;
    end
  // FSM state register
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) state_q <= IDLE;
    else state_q <= state_d;
  // FSM next state: start bit opens a frame, last bit goes to CHECK, stall aborts
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && bit_ev && !din) state_d = RECV;
    else if (timeout) state_d = IDLE;
    else if (state_q == RECV && bit_ev && bcnt_q == 4'(FRAME_LEN - 2)) state_d = CHECK;
    else if (state_q == CHECK) state_d = IDLE;
  end
  // FSM outputs: shift register, counters and sticky error flags (set beats clear)
  always_comb begin
    bcnt_d = state_q != RECV ? '0 : bit_ev ? bcnt_q + 4'd1 : bcnt_q;
    shr_d = (state_q == RECV && bit_ev) ? {din, shr_q[9:1]} : shr_q;
    tmo_d = (state_q != RECV || bit_ev) ? '0 : tmo_q + TW'(1);
    perr_d = (state_q == CHECK && !par_ok) || (perr_q && !bus.clr_err);
    ferr_d = (state_q == CHECK && !stop_ok) || timeout || (ferr_q && !bus.clr_err);
    ovf_d = (push && full && !bus.rd_en) || (ovf_q && !bus.clr_err);
  end
  // datapath and flag registers
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      bcnt_q <= '0;
      shr_q <= '0;
      tmo_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      shr_q <= shr_d;
      tmo_q <= tmo_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
    end
  ps2_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .RSTN(RSTN),
    .push(push),
    .din(shr_q[7:0]),
    .pop(bus.rd_en),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // status word assembly; data field reads zero when empty
  always_comb begin
    status = '0;
    status[7:0] = empty ? 8'h00 : head;
    status[READY] = !empty;
    status[OVF] = ovf_q;
    status[PERR] = perr_q;
    status[FERR] = ferr_q;
    status[CNT_LSB +: 4] = 4'(count);
  end
  assign bus.status = status;
  assign bus.irq = !empty;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed scenarios for the PS/2 keyboard receiver
module tb_ps2_kbd_rx;
  localparam int TMO = 500;
  localparam int H = 20;
  logic clk = 1'b0;
  logic RSTN = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ps2_kbd_rx_if bus();
  ps2_kbd_rx #(.FIFO_AW(3), .FILTER(4), .TIMEOUT(TMO)) dut (.clk(clk), .RSTN(RSTN), .bus(bus));
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [10:0] frame(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_after);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      cyc(H);
      bus.ps2_clk = 1'b0;
      cyc(H);
      bus.ps2_clk = 1'b1;
      if (i == glitch_after) begin
        cyc(3);
        bus.ps2_clk = 1'b0;
        cyc(2);
        bus.ps2_clk = 1'b1;
      end
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop, input int glitch_after);
    send_bits(frame(d, pflip, stop), 11, glitch_after);
    bus.ps2_data = 1'b1;
    cyc(10);
  endtask
  task automatic pulse_rd();
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
    cyc(1);
  endtask
  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    cyc(1);
  endtask
  task automatic test_reset();
    RSTN = 1'b0;
    cyc(10);
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL reset_status: got %h want %h", bus.status, 32'h0); end
    tests++;
    if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    RSTN = 1'b1;
    cyc(5);
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL post_reset_status: got %h want %h", bus.status, 32'h0); end
  endtask
  task automatic test_clean();
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    tests++;
    if (bus.status !== 32'h0000111C) begin fails++; $display("FAIL clean_status: got %h want %h", bus.status, 32'h0000111C); end
    tests++;
    if (bus.irq !== 1'b1) begin fails++; $display("FAIL clean_irq: got %b want 1", bus.irq); end
    pulse_rd();
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL clean_pop: got %h want %h", bus.status, 32'h0); end
    tests++;
    if (bus.irq !== 1'b0) begin fails++; $display("FAIL clean_pop_irq: got %b want 0", bus.irq); end
  endtask
  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    tests++;
    if (bus.status !== 32'h00000400) begin fails++; $display("FAIL parity_status: got %h want %h", bus.status, 32'h00000400); end
    tests++;
    if (bus.irq !== 1'b0) begin fails++; $display("FAIL parity_irq: got %b want 0", bus.irq); end
    pulse_clr();
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL parity_clr: got %h want %h", bus.status, 32'h0); end
  endtask
  task automatic test_stop();
    send_frame(8'h33, 1'b1, 1'b0, -1);
    tests++;
    if (bus.status !== 32'h00000C00) begin fails++; $display("FAIL stop_par_status: got %h want %h", bus.status, 32'h00000C00); end
    pulse_clr();
  endtask
  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, -1);
    tests++;
    if (bus.status !== 32'h00008301) begin fails++; $display("FAIL ovf_status: got %h want %h", bus.status, 32'h00008301); end
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (bus.status[7:0] !== 8'(i)) begin fails++; $display("FAIL ovf_pop%0d: got %h want %h", i, bus.status[7:0], 8'(i)); end
      pulse_rd();
    end
    tests++;
    if (bus.status !== 32'h00000200) begin fails++; $display("FAIL ovf_drained: got %h want %h", bus.status, 32'h00000200); end
    pulse_rd();
    tests++;
    if (bus.status !== 32'h00000200) begin fails++; $display("FAIL empty_pop: got %h want %h", bus.status, 32'h00000200); end
    pulse_clr();
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL ovf_clr: got %h want %h", bus.status, 32'h0); end
  endtask
  task automatic test_timeout();
    send_bits(frame(8'h05, 1'b0, 1'b1), 4, -1);
    bus.ps2_data = 1'b1;
    cyc(TMO + 10);
    tests++;
    if (bus.status !== 32'h00000800) begin fails++; $display("FAIL timeout_status: got %h want %h", bus.status, 32'h00000800); end
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    tests++;
    if (bus.status !== 32'h0000195A) begin fails++; $display("FAIL after_timeout: got %h want %h", bus.status, 32'h0000195A); end
    pulse_rd();
    pulse_clr();
  endtask
  task automatic test_glitch();
    bus.ps2_data = 1'b0;
    cyc(5);
    bus.ps2_clk = 1'b0;
    cyc(2);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(10);
    tests++;
    if (bus.status !== 32'h0) begin fails++; $display("FAIL idle_glitch: got %h want %h", bus.status, 32'h0); end
    send_frame(8'hF0, 1'b0, 1'b1, 4);
    tests++;
    if (bus.status[7:0] !== 8'hF0) begin fails++; $display("FAIL glitch_byte: got %h want %h", bus.status[7:0], 8'hF0); end
    tests++;
    if (bus.status !== 32'h000011F0) begin fails++; $display("FAIL glitch_status: got %h want %h", bus.status, 32'h000011F0); end
  endtask
  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    test_reset();
    test_clean();
    test_parity();
    test_stop();
    test_overflow();
    test_timeout();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
